// File: rtl/avalon_csr_bank.sv
// avalon_csr_bank: parametrised Avalon-MM slave register bank.
// Word map (word index = slave_address[ADDR_W-1:2]):
//   0               VERSION (read-only)
//   1               SNAP    (write bit0=1 captures stat_in; read returns capture count)
//   2               ERR     (read returns illegal-access count; any write clears it)
//   3..2+N_CTRL     control words (read/write, word 0 has self-clearing pulse bits)
//   next N_STAT     status shadow words (read-only, coherent snapshot of stat_in)
// Read latency is one cycle; readdatavalid is a single-cycle qualifier.
module avalon_csr_bank #(
    parameter int          WIDTH       = 32,
    parameter int          ADDR_W      = 6,
    parameter int          N_CTRL      = 4,
    parameter int          N_STAT      = 8,
    parameter logic [63:0] SYS_VERSION = 64'd21,
    parameter logic [63:0] CTRL_RESET  = 64'd0,
    parameter logic [63:0] PULSE_MASK  = 64'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         slave_address,
    input  logic                      slave_read,
    input  logic                      slave_write,
    input  logic [WIDTH-1:0]          slave_writedata,
    output logic [WIDTH-1:0]          slave_readdata,
    output logic                      slave_readdatavalid,
    output logic [N_CTRL*WIDTH-1:0]   ctrl_out,
    input  logic [N_STAT*WIDTH-1:0]   stat_in,
    output logic                      snap_pulse
);

    localparam int IDX_W     = ADDR_W - 2;
    localparam int CTRL_BASE = 3;
    localparam int STAT_BASE = 3 + N_CTRL;
    localparam int N_WORDS   = 3 + N_CTRL + N_STAT;

    localparam logic [WIDTH-1:0] VERSION_C = SYS_VERSION[WIDTH-1:0];
    localparam logic [WIDTH-1:0] CRESET_C  = CTRL_RESET[WIDTH-1:0];
    localparam logic [WIDTH-1:0] PMASK_C   = PULSE_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Elaboration-time sanity checks on the parameter set.
    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $error("avalon_csr_bank: WIDTH must be in 8..64");
    end
    if (N_CTRL < 1 || N_CTRL > 16) begin : g_bad_nctrl
        $error("avalon_csr_bank: N_CTRL must be in 1..16");
    end
    if (N_STAT < 1 || N_STAT > 32) begin : g_bad_nstat
        $error("avalon_csr_bank: N_STAT must be in 1..32");
    end
    if (N_WORDS > (1 << IDX_W)) begin : g_bad_map
        $error("avalon_csr_bank: word map does not fit in ADDR_W");
    end

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      idx_ext_s;
    logic             aligned_s;
    logic             mapped_s;
    logic             rd_req_s;
    logic             wr_req_s;
    logic             both_s;
    logic             is_ro_s;
    logic             legal_rd_s;
    logic             legal_wr_s;
    logic             illegal_s;
    logic             snap_wr_s;
    logic             err_clr_s;

    assign idx_s     = slave_address[ADDR_W-1:2];
    assign idx_ext_s = 32'(idx_s);
    assign aligned_s = (slave_address[1:0] == 2'b00);
    assign mapped_s  = (idx_ext_s < 32'(N_WORDS));
    assign rd_req_s  = slave_read & ~slave_write;
    assign wr_req_s  = slave_write & ~slave_read;
    assign both_s    = slave_read & slave_write;
    assign is_ro_s   = (idx_ext_s == 32'd0) ||
                       ((idx_ext_s >= 32'(STAT_BASE)) && (idx_ext_s < 32'(N_WORDS)));

    assign legal_rd_s = rd_req_s & aligned_s & mapped_s;
    assign legal_wr_s = wr_req_s & aligned_s & mapped_s & ~is_ro_s;

    // A single-direction access is illegal when misaligned, unmapped or a
    // write to a read-only word; simultaneous read+write is always illegal.
    assign illegal_s = both_s
                     | ((rd_req_s | wr_req_s) & ~(aligned_s & mapped_s))
                     | (wr_req_s & aligned_s & mapped_s & is_ro_s);

    assign snap_wr_s = legal_wr_s & (idx_ext_s == 32'd1) & slave_writedata[0];
    assign err_clr_s = legal_wr_s & (idx_ext_s == 32'd2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ctrl_q     [N_CTRL];
    logic [WIDTH-1:0] ctrl_d     [N_CTRL];
    logic [WIDTH-1:0] shadow_q   [N_STAT];
    logic [WIDTH-1:0] shadow_d   [N_STAT];
    logic [WIDTH-1:0] snap_cnt_q;
    logic [WIDTH-1:0] snap_cnt_d;
    logic [WIDTH-1:0] err_q;
    logic [WIDTH-1:0] err_d;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;
    logic             rvalid_q;
    logic             rvalid_d;
    logic             snap_pulse_q;
    logic             snap_pulse_d;
    logic [WIDTH-1:0] rd_word_s;

    // Control word next state: legal writes load, pulse bits of word 0 self-clear.
    always_comb begin
        for (int k = 0; k < N_CTRL; k++) begin
            if (legal_wr_s && (idx_ext_s == 32'(CTRL_BASE + k))) begin
                ctrl_d[k] = slave_writedata;
            end else if (k == 0) begin
                ctrl_d[k] = ctrl_q[k] & ~PMASK_C;
            end else begin
                ctrl_d[k] = ctrl_q[k];
            end
        end
    end

    // Snapshot shadow, capture counter and capture pulse next state.
    always_comb begin
        for (int k = 0; k < N_STAT; k++) begin
            if (snap_wr_s) begin
                shadow_d[k] = stat_in[k*WIDTH +: WIDTH];
            end else begin
                shadow_d[k] = shadow_q[k];
            end
        end
        if (snap_wr_s) begin
            snap_cnt_d = snap_cnt_q + ONE_C;
        end else begin
            snap_cnt_d = snap_cnt_q;
        end
        snap_pulse_d = snap_wr_s;
    end

    // Illegal-access counter: clear on write, else saturating increment.
    always_comb begin
        if (err_clr_s) begin
            err_d = '0;
        end else if (illegal_s && (err_q != {WIDTH{1'b1}})) begin
            err_d = err_q + ONE_C;
        end else begin
            err_d = err_q;
        end
    end

    // Read multiplexer over the current register contents.
    always_comb begin
        rd_word_s = '0;
        if (idx_ext_s == 32'd0) begin
            rd_word_s = VERSION_C;
        end else if (idx_ext_s == 32'd1) begin
            rd_word_s = snap_cnt_q;
        end else if (idx_ext_s == 32'd2) begin
            rd_word_s = err_q;
        end else begin
            for (int k = 0; k < N_CTRL; k++) begin
                if (idx_ext_s == 32'(CTRL_BASE + k)) begin
                    rd_word_s = ctrl_q[k];
                end else begin
                    rd_word_s = rd_word_s;
                end
            end
            for (int k = 0; k < N_STAT; k++) begin
                if (idx_ext_s == 32'(STAT_BASE + k)) begin
                    rd_word_s = shadow_q[k];
                end else begin
                    rd_word_s = rd_word_s;
                end
            end
        end
    end

    // Read response: legal reads return the word, bad single reads return 0,
    // read+write together gives no response; data holds when idle.
    always_comb begin
        if (legal_rd_s) begin
            rdata_d = rd_word_s;
        end else if (rd_req_s) begin
            rdata_d = '0;
        end else begin
            rdata_d = rdata_q;
        end
        rvalid_d = rd_req_s;
    end

    // Register update with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= CRESET_C;
            end
            for (int k = 0; k < N_STAT; k++) begin
                shadow_q[k] <= '0;
            end
            snap_cnt_q   <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            snap_pulse_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= ctrl_d[k];
            end
            for (int k = 0; k < N_STAT; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            snap_cnt_q   <= snap_cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            snap_pulse_q <= snap_pulse_d;
        end
    end

    // Output packing.
    for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_out
        assign ctrl_out[g*WIDTH +: WIDTH] = ctrl_q[g];
    end

    assign slave_readdata      = rdata_q;
    assign slave_readdatavalid = rvalid_q;
    assign snap_pulse          = snap_pulse_q;

endmodule

// File: tb/tb_avalon_csr_bank.sv
// Directed self-checking bench for avalon_csr_bank.
// Main instance: default geometry with PULSE_MASK=1 (word map 0x00..0x38).
// Small instance: WIDTH=8 so the ERR counter can be driven to saturation.
module tb_avalon_csr_bank;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    slave_address = 6'd0;
    logic          slave_read = 1'b0;
    logic          slave_write = 1'b0;
    logic [31:0]   slave_writedata = 32'd0;
    logic [31:0]   slave_readdata;
    logic          slave_readdatavalid;
    logic [127:0]  ctrl_out;
    logic [255:0]  stat_in = 256'd0;
    logic          snap_pulse;

    logic [4:0]    s_address = 5'd0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [7:0]    s_writedata = 8'd0;
    logic [7:0]    s_readdata;
    logic          s_readdatavalid;
    logic [7:0]    s_ctrl_out;
    logic [7:0]    s_stat_in = 8'd0;
    logic          s_snap_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        rv;

    always #5 clk = ~clk;

    avalon_csr_bank #(
        .WIDTH(32), .ADDR_W(6), .N_CTRL(4), .N_STAT(8),
        .SYS_VERSION(64'd21), .CTRL_RESET(64'd0), .PULSE_MASK(64'h1)
    ) dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
        .ctrl_out(ctrl_out), .stat_in(stat_in), .snap_pulse(snap_pulse)
    );

    avalon_csr_bank #(
        .WIDTH(8), .ADDR_W(5), .N_CTRL(1), .N_STAT(1),
        .SYS_VERSION(64'd21), .CTRL_RESET(64'd0), .PULSE_MASK(64'h0)
    ) dut_small (
        .clk(clk), .reset(reset),
        .slave_address(s_address), .slave_read(s_read),
        .slave_write(s_write), .slave_writedata(s_writedata),
        .slave_readdata(s_readdata), .slave_readdatavalid(s_readdatavalid),
        .ctrl_out(s_ctrl_out), .stat_in(s_stat_in), .snap_pulse(s_snap_pulse)
    );

    // One write cycle on the main port; returns 1 ns after the sampling edge.
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data);
        slave_address   = addr;
        slave_writedata = data;
        slave_write     = 1'b1;
        @(posedge clk); #1;
        slave_write     = 1'b0;
    endtask

    // One read cycle on the main port; captures the response after the edge.
    task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic valid);
        slave_address = addr;
        slave_read    = 1'b1;
        @(posedge clk); #1;
        slave_read    = 1'b0;
        data  = slave_readdata;
        valid = slave_readdatavalid;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (slave_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", slave_readdatavalid); end
        n_checks++; if (slave_readdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", slave_readdata); end
        n_checks++; if (ctrl_out !== 128'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_out); end
        n_checks++; if (snap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_snap_pulse: got %b expected 0", snap_pulse); end
        do_read(6'h00, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd21) begin n_fail++; $display("FAIL version_read: got %h/%b expected 15/1", rd, rv); end
        idle_cycle();
        n_checks++; if (slave_readdatavalid !== 1'b0 || slave_readdata !== 32'd21) begin n_fail++; $display("FAIL rvalid_drop_hold: got %h/%b expected 15/0", slave_readdata, slave_readdatavalid); end
        do_read(6'h08, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL reset_err: got %h/%b expected 0/1", rd, rv); end
    endtask

    task automatic test_pulse_and_ctrl();
        do_write(6'h0C, 32'h0000_0003);
        n_checks++; if (ctrl_out[31:0] !== 32'd3) begin n_fail++; $display("FAIL pulse_high: got %h expected 3", ctrl_out[31:0]); end
        idle_cycle();
        n_checks++; if (ctrl_out[31:0] !== 32'd2) begin n_fail++; $display("FAIL pulse_clear: got %h expected 2", ctrl_out[31:0]); end
        do_read(6'h0C, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd2) begin n_fail++; $display("FAIL ctrl0_readback: got %h/%b expected 2/1", rd, rv); end
        do_write(6'h10, 32'h0000_1234);
        do_read(6'h10, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'h1234) begin n_fail++; $display("FAIL ctrl1_rd_after_wr: got %h/%b expected 1234/1", rd, rv); end
        n_checks++; if (ctrl_out[63:32] !== 32'h1234) begin n_fail++; $display("FAIL ctrl1_out: got %h expected 1234", ctrl_out[63:32]); end
        do_write(6'h18, 32'hDEAD_BEEF);
        n_checks++; if (ctrl_out[127:96] !== 32'hDEAD_BEEF || ctrl_out[31:0] !== 32'd2) begin n_fail++; $display("FAIL ctrl3_out: got %h expected deadbeef_..._00000002", ctrl_out); end
    endtask

    task automatic test_snapshot();
        stat_in[31:0]    = 32'h0000_00A5;
        stat_in[255:224] = 32'h0000_0077;
        do_write(6'h04, 32'd1);
        n_checks++; if (snap_pulse !== 1'b1) begin n_fail++; $display("FAIL snap_pulse_high: got %b expected 1", snap_pulse); end
        stat_in[31:0] = 32'h0000_00FF;
        idle_cycle();
        n_checks++; if (snap_pulse !== 1'b0) begin n_fail++; $display("FAIL snap_pulse_once: got %b expected 0", snap_pulse); end
        do_read(6'h1C, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'hA5) begin n_fail++; $display("FAIL shadow0: got %h/%b expected a5/1", rd, rv); end
        do_read(6'h38, rd, rv);
        n_checks++; if (rd !== 32'h77) begin n_fail++; $display("FAIL shadow7: got %h expected 77", rd); end
        do_read(6'h04, rd, rv);
        n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL snap_count1: got %h expected 1", rd); end
        do_write(6'h04, 32'd0);
        n_checks++; if (snap_pulse !== 1'b0) begin n_fail++; $display("FAIL snap_bit0_zero: got %b expected 0", snap_pulse); end
        // Back-to-back captures keep the pulse high.
        slave_address = 6'h04; slave_writedata = 32'd1; slave_write = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (snap_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse1: got %b expected 1", snap_pulse); end
        @(posedge clk); #1;
        slave_write = 1'b0;
        n_checks++; if (snap_pulse !== 1'b1) begin n_fail++; $display("FAIL b2b_pulse2: got %b expected 1", snap_pulse); end
        idle_cycle();
        n_checks++; if (snap_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %b expected 0", snap_pulse); end
        do_read(6'h04, rd, rv);
        n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL snap_count3: got %h expected 3", rd); end
        do_read(6'h1C, rd, rv);
        n_checks++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL shadow0_recap: got %h expected ff", rd); end
        do_read(6'h08, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL err_after_snap: got %h expected 0", rd); end
    endtask

    task automatic test_errors();
        do_write(6'h00, 32'h0000_00AA);
        do_read(6'h02, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL misaligned_read: got %h/%b expected 0/1", rd, rv); end
        slave_address = 6'h0C; slave_writedata = 32'hFF; slave_read = 1'b1; slave_write = 1'b1;
        @(posedge clk); #1;
        slave_read = 1'b0; slave_write = 1'b0;
        n_checks++; if (slave_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rdwr_no_valid: got %b expected 0", slave_readdatavalid); end
        n_checks++; if (ctrl_out[31:0] !== 32'd2) begin n_fail++; $display("FAIL rdwr_no_write: got %h expected 2", ctrl_out[31:0]); end
        do_read(6'h08, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd3) begin n_fail++; $display("FAIL err_count3: got %h/%b expected 3/1", rd, rv); end
        do_write(6'h08, 32'h0);
        do_read(6'h08, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL err_cleared: got %h expected 0", rd); end
        do_read(6'h3C, rd, rv);
        n_checks++; if (rv !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h/%b expected 0/1", rd, rv); end
        do_write(6'h20, 32'h5555);
        do_read(6'h20, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL status_ro: got %h expected 0", rd); end
        do_read(6'h08, rd, rv);
        n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL err_count2: got %h expected 2", rd); end
    endtask

    task automatic test_async_reset();
        slave_address = 6'h10; slave_read = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h1234) begin n_fail++; $display("FAIL pre_reset_read: got %h/%b expected 1234/1", slave_readdata, slave_readdatavalid); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (slave_readdatavalid !== 1'b0 || slave_readdata !== 32'd0) begin n_fail++; $display("FAIL async_reset_read: got %h/%b expected 0/0", slave_readdata, slave_readdatavalid); end
        n_checks++; if (ctrl_out !== 128'd0) begin n_fail++; $display("FAIL async_reset_ctrl: got %h expected 0", ctrl_out); end
        slave_read = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        n_checks++; if (slave_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL dropped_txn: got %b expected 0", slave_readdatavalid); end
        do_read(6'h04, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_snap_count: got %h expected 0", rd); end
        do_read(6'h1C, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_shadow: got %h expected 0", rd); end
        do_read(6'h08, rd, rv);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_err2: got %h expected 0", rd); end
    endtask

    task automatic test_err_saturate();
        s_address = 5'h08; s_read = 1'b1; s_write = 1'b1;
        repeat (260) @(posedge clk);
        #1 s_write = 1'b0;
        @(posedge clk); #1 s_read = 1'b0;
        n_checks++; if (s_readdatavalid !== 1'b1 || s_readdata !== 8'hFF) begin n_fail++; $display("FAIL err_saturated: got %h/%b expected ff/1", s_readdata, s_readdatavalid); end
        s_address = 5'h00; s_read = 1'b1; s_write = 1'b1;
        @(posedge clk); #1 s_write = 1'b0; s_address = 5'h08;
        @(posedge clk); #1 s_read = 1'b0;
        n_checks++; if (s_readdata !== 8'hFF) begin n_fail++; $display("FAIL err_stays_sat: got %h expected ff", s_readdata); end
        s_address = 5'h08; s_writedata = 8'h00; s_write = 1'b1;
        @(posedge clk); #1 s_write = 1'b0; s_read = 1'b1;
        @(posedge clk); #1 s_read = 1'b0;
        n_checks++; if (s_readdata !== 8'h00) begin n_fail++; $display("FAIL err_sat_clear: got %h expected 0", s_readdata); end
        s_address = 5'h00; s_read = 1'b1;
        @(posedge clk); #1 s_read = 1'b0;
        n_checks++; if (s_readdata !== 8'd21) begin n_fail++; $display("FAIL small_version: got %h expected 15", s_readdata); end
    endtask

    initial begin
        test_reset();
        test_pulse_and_ctrl();
        test_snapshot();
        test_errors();
        test_async_reset();
        test_err_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_csr_bank.md
Name: avalon_csr_bank

Overview:
- Parametrised Avalon-MM slave register bank; successor to the fixed one-input/four-output host-port wrapper.
- Provides N_CTRL read/write control words, N_STAT status words read through a coherent snapshot shadow, a version word and an illegal-access counter.
- Adds self-clearing pulse bits, a one-cycle read-valid strobe and access-error accounting.
- Sits between the HPS bridge and testbench/DUT control and status vectors.

Parameters:
- WIDTH, 32, data word width; 8..64.
- ADDR_W, 6, byte address width. Word index = slave_address[ADDR_W-1:2].
- N_CTRL, 4, number of control words; 1..16.
- N_STAT, 8, number of status words; 1..32.
- SYS_VERSION, 21, constant returned at word 0.
- CTRL_RESET, 0, reset value of every control word.
- PULSE_MASK, 0, bit mask applied to control word 0; masked bits self-clear.
- Constraint: 3+N_CTRL+N_STAT <= 2^(ADDR_W-2), checked at elaboration.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- slave_address  in  ADDR_W  byte address
- slave_read  in  1  read request
- slave_write  in  1  write request
- slave_writedata  in  WIDTH  write data
- slave_readdata  out  WIDTH  registered read data
- slave_readdatavalid  out  1  one-cycle pulse qualifying slave_readdata
- ctrl_out  out  N_CTRL*WIDTH  control words, word k at bits [k*WIDTH +: WIDTH]
- stat_in  in  N_STAT*WIDTH  live status words, same packing
- snap_pulse  out  1  high for one cycle after each snapshot is captured

Behaviour:
- Word map:
  - idx 0: VERSION, read-only.
  - idx 1: SNAP. A write with bit0=1 captures all stat_in into the shadow. A read returns the snapshot count, which wraps modulo 2^WIDTH.
  - idx 2: ERR. A read returns the illegal-access count. Any write clears it to 0.
  - idx 3..2+N_CTRL: control words, read/write.
  - next N_STAT indices: status shadow words, read-only.
- Legal access: exactly one of read/write is high, address[1:0]==0, and the index is mapped.
- Illegal access, counted:
  - read and write both high: no state change, no readdatavalid.
  - misaligned or unmapped address: a read returns 0 with readdatavalid=1; a write is ignored.
  - write to a read-only word (0, or any status word).
- ERR behaviour: increments once per illegal cycle and saturates at all-ones. A clearing write to ERR in the same cycle cannot itself be illegal.
- Write timing: write sampled at edge T; the new ctrl_out value is visible after T. Writes to idx 1 with bit0=0 have no effect and are not errors.
- Pulse bits: in control word 0, bits set in PULSE_MASK that are written as 1 read and drive as 1 for exactly one cycle, then return to 0 at the next edge. Unmasked bits hold their value.
- Snapshot: a SNAP write at edge T copies stat_in (sampled at T) into the shadow, increments the snapshot count, and sets snap_pulse=1 during cycle T+1. Back-to-back SNAP writes capture every cycle and keep snap_pulse high continuously.
- Read timing:
  - read sampled at edge T; slave_readdata and slave_readdatavalid=1 appear after T (latency 1).
  - readdatavalid drops the next cycle unless another read occurs.
  - readdata holds its last value when no read is sampled.
- Read/write interaction: a read of a control word in the cycle after a write to it returns the new value.
- Reset (asynchronous, any time, including mid-access):
  - control words = CTRL_RESET; shadow, snapshot count and ERR = 0.
  - readdata = 0, readdatavalid = 0, snap_pulse = 0.
  - a transaction in flight is dropped.

Test Plan:
1. Reset, then read idx 0 (address 0x00) -> readdatavalid high one cycle later with readdata=21, ctrl_out all 0, ERR=0.
2. PULSE_MASK=0x1: write 0x0000_0003 to address 0x0C -> ctrl word0 = 3 for one cycle, then 2; read back returns 2.
3. Drive stat_in word0=0xA5, write 1 to address 0x04, change stat_in word0 to 0xFF, then read the first status word -> returns 0xA5; reading SNAP returns 1; snap_pulse high for exactly one cycle.
4. Write to address 0x00, read address 0x02 (misaligned), assert read and write together, then read ERR -> ERR=3; the misaligned read returned 0 with valid. Then write to ERR and read it again -> 0.
5. Assert reset asynchronously mid-cycle while readdatavalid=1 and ctrl word1=0x1234 -> both clear immediately without waiting for a clock edge.
6. Issue ERR increments from the all-ones value -> ERR stays at all-ones (saturates).
